// File: rtl/aibcr3_dll_dlyline_ctrl.sv
// Tap-select controller for the DLL delay line: binary code -> glitch-free thermometer bus with scan access.
// Optional code clamping is enabled by defining AIBCR3_DLL_CODE_CLAMP_EN.
module aibcr3_dll_dlyline_ctrl #(
    parameter int NTAPS      = 64,
    parameter int CODE_W     = 7,
    parameter int STEP_DIV   = 1,
    parameter int SETTLE_CYC = 4,
    parameter int MAX_CODE   = NTAPS
) (
    input  logic              CLKIN,
    input  logic              RSTb,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_vld,
    output logic              code_rdy,
    output logic [NTAPS-1:0]  bk,
    output logic [CODE_W-1:0] cur_code,
    output logic              busy,
    output logic              done,
    output logic              clamp_hit,
    input  logic              iSE,
    input  logic              iSI,
    output logic              SOOUT
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

`ifdef AIBCR3_DLL_CODE_CLAMP_EN
    localparam int CAP = (MAX_CODE > NTAPS) ? NTAPS : MAX_CODE;
`else
    // MAX_CODE deliberately has no effect without clamping
    localparam int CAP = NTAPS + 0 * MAX_CODE;
`endif
    localparam logic [CODE_W-1:0] LIMIT = CODE_W'(CAP);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVE   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RESYNC = 2'd3;

    logic [1:0]        r_state;
    logic [NTAPS-1:0]  r_bk;
    logic [CODE_W-1:0] r_cur;
    logic [CODE_W-1:0] r_tgt;
    logic [DIV_W-1:0]  r_div;
    logic [SET_W-1:0]  r_set;
    logic              r_done;
    logic              r_ise_q;
    logic              r_resync_idle;

    logic              w_rdy;
    logic              w_accept;
    logic [CODE_W-1:0] w_tgt_req;
    logic [CODE_W-1:0] w_pop;
    logic [NTAPS-1:0]  w_therm;
    logic [NTAPS-1:0]  w_up_bit;
    logic [NTAPS-1:0]  w_dn_bit;

    assign w_rdy     = (r_state == ST_IDLE) && !iSE;
    assign w_accept  = w_rdy && code_vld;
    assign w_tgt_req = (code_in > LIMIT) ? LIMIT : code_in;

    // Per-tap decode: popcount/thermometer for resync, one-hot masks for single-tap steps
    always_comb begin
        w_pop    = '0;
        w_therm  = '0;
        w_up_bit = '0;
        w_dn_bit = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            w_pop = w_pop + CODE_W'(r_bk[i]);
        end
        for (int unsigned i = 0; i < NTAPS; i++) begin
            w_therm[i]  = (CODE_W'(i) < w_pop);
            w_up_bit[i] = (CODE_W'(i) == r_cur);
            w_dn_bit[i] = (CODE_W'(i + 1) == r_cur);
        end
    end

    always_ff @(posedge CLKIN or negedge RSTb) begin
        if (!RSTb) begin
            r_state       <= ST_IDLE;
            r_bk          <= '0;
            r_cur         <= '0;
            r_tgt         <= '0;
            r_div         <= '0;
            r_set         <= '0;
            r_done        <= 1'b0;
            r_ise_q       <= 1'b0;
            r_resync_idle <= 1'b0;
        end else begin
            r_ise_q <= iSE;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_tgt <= w_tgt_req;
                r_div <= DIV_LOAD;
            end
            if (iSE) begin
                r_bk <= {r_bk[NTAPS-2:0], iSI};
            end else if (r_ise_q) begin
                // A request accepted on the scan-exit edge makes the resync head for it instead of IDLE
                r_state       <= ST_RESYNC;
                r_resync_idle <= ((r_state == ST_IDLE) && !code_vld) ||
                                 ((r_state == ST_RESYNC) && r_resync_idle);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_state <= ST_MOVE;
                        end
                    end
                    ST_MOVE: begin
                        if (r_cur == r_tgt) begin
                            r_state <= ST_SETTLE;
                            r_set   <= SET_LOAD;
                        end else if (r_div == '0) begin
                            r_div <= DIV_LOAD;
                            if (r_cur < r_tgt) begin
                                r_bk  <= r_bk | w_up_bit;
                                r_cur <= r_cur + CODE_W'(1);
                            end else begin
                                r_bk  <= r_bk & ~w_dn_bit;
                                r_cur <= r_cur - CODE_W'(1);
                            end
                        end else begin
                            r_div <= r_div - DIV_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (r_set == '0) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_set <= r_set - SET_W'(1);
                        end
                    end
                    ST_RESYNC: begin
                        r_bk    <= w_therm;
                        r_cur   <= w_pop;
                        r_div   <= DIV_LOAD;
                        r_state <= r_resync_idle ? ST_IDLE : ST_MOVE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef AIBCR3_DLL_CODE_CLAMP_EN
    logic r_clamp;

    always_ff @(posedge CLKIN or negedge RSTb) begin
        if (!RSTb) begin
            r_clamp <= 1'b0;
        end else if (w_accept && (code_in > LIMIT)) begin
            r_clamp <= 1'b1;
        end
    end

    assign clamp_hit = r_clamp;
`else
    assign clamp_hit = 1'b0;
`endif

    assign code_rdy = w_rdy;
    assign bk       = r_bk;
    assign cur_code = r_cur;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done && !iSE;
    assign SOOUT    = r_bk[NTAPS-1];

endmodule

// File: doc/aibcr3_dll_dlyline_ctrl.md
Name: aibcr3_dll_dlyline_ctrl

Overview:
- Parametrised tap-select controller for the DLL delay line.
- Converts a binary delay code into the thermometer tap-select bus `bk`, stepping one tap per step interval so that adjacent cells never glitch.
- Holds `bk` in a scannable register chain (CLKIN, iSE, iSI, SOOUT) so DFT can load or observe the tap setting directly.
- Sits between the DLL phase-detector/loop logic and the delay-line cell array.

Parameters:
- NTAPS, 64, number of delay taps (`bk` width), 4..256.
- CODE_W, 7, code width; must satisfy 2**CODE_W > NTAPS.
- STEP_DIV, 1, CLKIN cycles per one-tap step, >=1.
- SETTLE_CYC, 4, cycles waited after reaching target before `done`, >=1.
- MAX_CODE, NTAPS, upper clamp bound; used only with the optional feature.

Ports:
- CLKIN  input  1  controller clock.
- RSTb  input  1  asynchronous active-low reset.
- code_in  input  CODE_W  requested delay code (number of active taps).
- code_vld  input  1  request valid.
- code_rdy  output  1  request accepted when code_vld&&code_rdy at CLKIN rise.
- bk  output  NTAPS  thermometer tap select; bk[i]=1 for i<cur_code.
- cur_code  output  CODE_W  present applied code.
- busy  output  1  state!=IDLE.
- done  output  1  one-cycle pulse: target reached and settled.
- clamp_hit  output  1  sticky flag: a request was clamped (optional feature).
- iSE  input  1  scan enable.
- iSI  input  1  scan in.
- SOOUT  output  1  scan out = bk[NTAPS-1].

Behaviour:
- Reset (RSTb=0, asynchronous): bk=0, cur_code=0, tgt=0, state=IDLE, done=0, clamp_hit=0, counters=0. Therefore SOOUT=0, busy=0, and code_rdy=!iSE.
- code_rdy is combinational: (state==IDLE) && !iSE.
- Accept: tgt<=min(code_in,NTAPS), div_cnt<=STEP_DIV-1, state<=MOVE.
- MOVE:
  - If cur_code==tgt: state<=SETTLE, set_cnt<=SETTLE_CYC-1.
  - Else if div_cnt==0: step one tap toward tgt and reload div_cnt<=STEP_DIV-1.
    - Up step: bk[cur_code]<=1, cur_code+1.
    - Down step: bk[cur_code-1]<=0, cur_code-1.
  - Else: div_cnt--.
  - Exactly one bk bit changes per step.
- SETTLE: if set_cnt==0, state<=IDLE and done<=1 for one cycle; else set_cnt--.
- Latency, accept at edge 0: done is high in the cycle following edge |tgt-cur|*STEP_DIV+SETTLE_CYC+1.
- Request equal to cur_code: no bk change; done follows after SETTLE_CYC+1 edges.
- Saturation: code_in>NTAPS saturates to NTAPS. cur_code never goes below 0 or above NTAPS.
- Scan (iSE=1), any state:
  - bk<={bk[NTAPS-2:0],iSI} each edge.
  - FSM, counters, cur_code and tgt are frozen; done is forced 0.
  - A state of IDLE stays IDLE.
- iSE falling edge (iSE was 1 last cycle, now 0): state<=RESYNC for one cycle.
  - RESYNC: p=popcount(bk); bk<=thermometer(p); cur_code<=p.
  - Then MOVE toward the retained tgt, which re-asserts done on completion, or IDLE if the prior state was IDLE.
  - RESYNC is the only cycle where multiple bk bits may change.
- Reset asserted mid-MOVE, mid-SETTLE or mid-scan: immediate clear to reset values; the pending target is lost.
- Requests arriving while busy are not accepted; code_vld may be held.

Optional Feature:
- Macro AIBCR3_DLL_CODE_CLAMP_EN.
- Defined:
  - Accepted code is clamped: tgt=min(code_in,MAX_CODE).
  - If code_in>MAX_CODE, clamp_hit<=1 (sticky until reset).
  - MAX_CODE>NTAPS is treated as NTAPS.
- Undefined:
  - Saturation at NTAPS only.
  - clamp_hit tied 0.
  - MAX_CODE unused.

Test Plan:
- Reset then code_in=5, code_vld pulse, STEP_DIV=1, SETTLE_CYC=4 -> bk goes 0x1,0x3,...,0x1F on edges 1..5; done high after edge 10; cur_code=5.
- From cur_code=5, request 2 with STEP_DIV=3 -> bk bits 4,3,2 clear at edges 3,6,9, one bit per step; done after edge 3*3+4+1=14.
- Request 100 with NTAPS=64 -> saturates; bk all ones, cur_code=64. With AIBCR3_DLL_CODE_CLAMP_EN and MAX_CODE=40 -> cur_code=40, clamp_hit=1.
- Raise iSE mid-MOVE at cur_code=10 (tgt=20), shift 64 bits of pattern 0xF0F0... -> SOOUT replays old bk MSB-first and the state is frozen. Drop iSE -> RESYNC sets bk to thermometer(32), cur_code=32; controller steps down to 20 and pulses done.
- Assert RSTb low during SETTLE -> bk=0, cur_code=0, busy=0, done=0 immediately without a clock edge.
- Request equal to cur_code=7 -> bk unchanged; done after SETTLE_CYC+1 edges; code_rdy low throughout.
